// File: rtl/msg_slice_sequencer_pkg.sv
// Shared constants for the message slice sequencer.
//  K/M/La    : message width, encoder parallelism, bits per symbol
//  W/NSLICE  : slice width and slices per message
//  CNT_W     : slice index width
//  state_e   : sequencer FSM encoding (ST_IDLE, ST_STREAM)
//  ORDER_*   : slice order select values
package msg_slice_sequencer_pkg;
  localparam int K      = 1024;
  localparam int M      = 32;
  localparam int La     = 8;
  localparam int W      = M * La;
  localparam int NSLICE = K / W;
  localparam int CNT_W  = $clog2(NSLICE);

  typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_e;

  localparam logic ORDER_ASC  = 1'b0;
  localparam logic ORDER_DESC = 1'b1;
endpackage

// File: rtl/msg_slice_sequencer_if.sv
// Message-in / slice-out bus of the slice sequencer.
//  master : message assembler + encoder side (drives msg_*, order, abort, slice_ready)
//  slave  : the sequencer (drives msg_ready, slice_*, msg_to_encode, busy)
interface msg_slice_sequencer_if;
  import msg_slice_sequencer_pkg::*;
  logic [K-1:0]     msg_in;
  logic             msg_valid;
  logic             msg_ready;
  logic             order;
  logic             abort;
  logic [W-1:0]     msg_to_encode;
  logic             slice_valid;
  logic             slice_ready;
  logic [CNT_W-1:0] slice_idx;
  logic             slice_last;
  logic             busy;

  modport master (
    output msg_in, msg_valid, order, abort, slice_ready,
    input  msg_ready, msg_to_encode, slice_valid, slice_idx, slice_last, busy
  );
  modport slave (
    input  msg_in, msg_valid, order, abort, slice_ready,
    output msg_ready, msg_to_encode, slice_valid, slice_idx, slice_last, busy
  );
endinterface

// File: rtl/msg_slice_sequencer_slice_select.sv
// slice_select: combinational W-bit mux of the message buffer by slice index.
//  data : NSLICE packed W-bit slices, slice i at data[i]
//  idx  : slice to present
//  en   : output forced to zero when low
//  dout : selected slice
module slice_select
  import msg_slice_sequencer_pkg::*;
(
  input  logic [NSLICE-1:0][W-1:0] data,
  input  logic [CNT_W-1:0]         idx,
  input  logic                     en,
  output logic [W-1:0]             dout
);
  // One-hot masked lanes OR-reduced; avoids a wide variable part-select.
  logic [NSLICE-1:0][W-1:0] lane;

  for (genvar g = 0; g < NSLICE; g++) begin : g_lane
    assign lane[g] = (en && idx == CNT_W'(g)) ? data[g] : '0;
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < NSLICE; i++) dout = dout | lane[i];
  end
endmodule

// File: rtl/msg_slice_sequencer.sv
// msg_slice_sequencer: captures one K-bit message on a valid/ready handshake and
// streams it as NSLICE W-bit slices (ascending or descending) with back-pressure.
//  clk, rst : clock, asynchronous active-high reset
//  bus      : slave side of msg_slice_sequencer_if (message in, slice stream out)
module msg_slice_sequencer
  import msg_slice_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  msg_slice_sequencer_if.slave bus
);
  if (K % W != 0 || NSLICE < 2) begin : g_bad_params
    $error("msg_slice_sequencer: K must be a multiple of W with at least 2 slices");
  end

  state_e           state_q, state_d;
  logic [K-1:0]     msg_buf_q, msg_buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             order_q, order_d;

  logic             valid, last, accept, capture;
  logic [CNT_W-1:0] idx;

  assign valid   = (state_q == ST_STREAM);
  assign last    = valid && (cnt_q == CNT_W'(NSLICE - 1));
  assign accept  = valid && bus.slice_ready;
  // Abort blocks capture so a message offered during a flush is never dropped silently.
  assign bus.msg_ready = !bus.abort && (!valid || (accept && last));
  assign capture = bus.msg_valid && bus.msg_ready;

  always_comb begin
    idx = '0;
    if (valid) idx = (order_q == ORDER_DESC) ? CNT_W'(NSLICE - 1) - cnt_q : cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    msg_buf_d = msg_buf_q;
    cnt_d     = cnt_q;
    order_d   = order_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (capture) begin
      // Covers both the idle capture and the back-to-back capture on the last beat.
      state_d   = ST_STREAM;
      msg_buf_d = bus.msg_in;
      order_d   = bus.order;
      cnt_d     = '0;
    end else if (accept) begin
      if (last) state_d = ST_IDLE;
      else      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      msg_buf_q <= '0;
      cnt_q     <= '0;
      order_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_buf_q <= msg_buf_d;
      cnt_q     <= cnt_d;
      order_q   <= order_d;
    end
  end

  slice_select u_sel (
    .data (msg_buf_q),
    .idx  (idx),
    .en   (valid),
    .dout (bus.msg_to_encode)
  );

  assign bus.slice_valid = valid;
  assign bus.slice_idx   = idx;
  assign bus.slice_last  = last;
  assign bus.busy        = valid;
endmodule
